// File: rtl/text_term_pkg.sv
// Shared constants, control codes, FSM states and address helpers for the
// 80x60 terminal write controller.
package text_term_pkg;

   localparam int COLS   = 80;
   localparam int ROWS   = 60;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 13;
   localparam int ROW_W  = 6;
   localparam int COL_W  = 7;

   localparam logic [7:0] CLEAR_CHAR   = 8'h20;
   localparam logic [7:0] CHR_BS       = 8'h08;
   localparam logic [7:0] CHR_LF       = 8'h0A;
   localparam logic [7:0] CHR_FF       = 8'h0C;
   localparam logic [7:0] CHR_CR       = 8'h0D;
   localparam logic [7:0] CHR_PRINT_LO = 8'h20;
   localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CLEAR_ROW = 2'd1,
      ST_CLEAR_ALL = 2'd2
   } state_t;

   // row*80 as (row<<6)+(row<<4), avoiding a multiplier.
   function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
      logic [ADDR_W-1:0] r;
      r = {{(ADDR_W-ROW_W){1'b0}}, row};
      return (r << 3'd6) + (r << 3'd4);
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return row_base(row) + {{(ADDR_W-COL_W){1'b0}}, col};
   endfunction

   function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row);
      return (row == ROW_LAST) ? {ROW_W{1'b0}} : row + 6'd1;
   endfunction

endpackage

// File: rtl/text_clear_seq.sv
// Clear address generator: after start, walks base..base+length-1 one address
// per cycle; done flags the final address.
module text_clear_seq
   import text_term_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] length,
   output logic [ADDR_W-1:0] addr,
   output logic              busy,
   output logic              done
);

   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] base_hold;
   logic [ADDR_W-1:0] last_idx;

   assign addr = base_hold + count;
   assign done = busy && (count == last_idx);

   // Offset counter; a start always restarts the walk from offset zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         busy      <= 1'b0;
         count     <= {ADDR_W{1'b0}};
         base_hold <= {ADDR_W{1'b0}};
         last_idx  <= {ADDR_W{1'b0}};
      end else if (start) begin
         busy      <= 1'b1;
         count     <= {ADDR_W{1'b0}};
         base_hold <= base;
         last_idx  <= length - ADDR_W'(1'b1);
      end else if (busy) begin
         if (count == last_idx) begin
            busy <= 1'b0;
         end else begin
            count <= count + ADDR_W'(1'b1);
         end
      end else begin
         count <= {ADDR_W{1'b0}};
      end
   end

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal-style writer for the 80x60 text buffer: places printable bytes at
// the cursor, handles BS/LF/CR/FF and sequences row and full-screen clears.
module text_term_ctrl
   import text_term_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] ascii_address,
   output logic [7:0]        ascii_data,
   output logic              ascii_wr_en,
   output logic [ADDR_W-1:0] cursor
);

   state_t            state;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic              clr_req;
   logic              drain;

   state_t            next_state;
   logic [ROW_W-1:0]  next_row;
   logic [COL_W-1:0]  next_col;
   logic              byte_wr;
   logic              byte_clr;
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        byte_data;

   logic [ADDR_W-1:0] clr_base;
   logic [ADDR_W-1:0] clr_len;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_busy;
   logic              clr_done;

   assign rx_ready = (state == ST_IDLE) && resetn;
   // The row is already advanced when the clear starts, so it names the new row.
   assign clr_base = (state == ST_CLEAR_ROW) ? row_base(row) : {ADDR_W{1'b0}};
   assign clr_len  = (state == ST_CLEAR_ROW) ? ADDR_W'(COLS) : ADDR_W'(CELLS);

   text_clear_seq u_clear_seq (
      .clk    (clk),
      .resetn (resetn),
      .start  (clr_req),
      .base   (clr_base),
      .length (clr_len),
      .addr   (clr_addr),
      .busy   (clr_busy),
      .done   (clr_done)
   );

   // Effect of the incoming byte on cursor, state and write port.
   always_comb begin
      next_state = ST_IDLE;
      next_row   = row;
      next_col   = col;
      byte_wr    = 1'b0;
      byte_clr   = 1'b0;
      byte_addr  = cell_addr(row, col);
      byte_data  = rx_data;
      if ((rx_data >= CHR_PRINT_LO) && (rx_data <= CHR_PRINT_HI)) begin
         byte_wr = 1'b1;
         if (col == COL_LAST) begin
            next_col   = {COL_W{1'b0}};
            next_row   = row_inc(row);
            next_state = ST_CLEAR_ROW;
            byte_clr   = 1'b1;
         end else begin
            next_col = col + 7'd1;
         end
      end else begin
         case (rx_data)
            CHR_LF: begin
               next_col   = {COL_W{1'b0}};
               next_row   = row_inc(row);
               next_state = ST_CLEAR_ROW;
               byte_clr   = 1'b1;
            end
            CHR_CR: begin
               next_col = {COL_W{1'b0}};
            end
            CHR_BS: begin
               if (col != {COL_W{1'b0}}) begin
                  next_col = col - 7'd1;
               end else if (row != {ROW_W{1'b0}}) begin
                  next_row = row - 6'd1;
                  next_col = COL_LAST;
               end else begin
                  next_col = col;
               end
               byte_wr   = 1'b1;
               byte_data = CLEAR_CHAR;
               byte_addr = cell_addr(next_row, next_col);
            end
            CHR_FF: begin
               next_row   = {ROW_W{1'b0}};
               next_col   = {COL_W{1'b0}};
               next_state = ST_CLEAR_ALL;
               byte_clr   = 1'b1;
            end
            default: begin
               next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Main FSM with registered write port and cursor.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= ST_CLEAR_ALL;
         row           <= {ROW_W{1'b0}};
         col           <= {COL_W{1'b0}};
         cursor        <= {ADDR_W{1'b0}};
         ascii_wr_en   <= 1'b0;
         ascii_address <= {ADDR_W{1'b0}};
         ascii_data    <= 8'h00;
         clr_req       <= 1'b1;
         drain         <= 1'b0;
      end else begin
         clr_req     <= 1'b0;
         drain       <= 1'b0;
         ascii_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  state       <= next_state;
                  row         <= next_row;
                  col         <= next_col;
                  cursor      <= cell_addr(next_row, next_col);
                  clr_req     <= byte_clr;
                  ascii_wr_en <= byte_wr;
                  if (byte_wr) begin
                     ascii_address <= byte_addr;
                     ascii_data    <= byte_data;
                  end
               end
            end
            ST_CLEAR_ROW, ST_CLEAR_ALL: begin
               // Leave one cycle after the final write so rx_ready stays low across it.
               if (clr_busy) begin
                  ascii_wr_en   <= 1'b1;
                  ascii_address <= clr_addr;
                  ascii_data    <= CLEAR_CHAR;
                  drain         <= clr_done;
               end else if (drain) begin
                  state <= ST_IDLE;
               end else begin
                  state <= state;
               end
            end
            default: begin
               state   <= ST_CLEAR_ALL;
               row     <= {ROW_W{1'b0}};
               col     <= {COL_W{1'b0}};
               cursor  <= {ADDR_W{1'b0}};
               clr_req <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Randomized bench for text_term_ctrl against a row/column screen model with
// an ordered queue of expected buffer writes.
module tb_text_term_ctrl;

   localparam int TB_COLS = 80;
   localparam int TB_ROWS = 60;

   typedef struct {
      int         addr;
      logic [7:0] data;
      bit         clr;
   } wr_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [12:0] ascii_address;
   logic [7:0]  ascii_data;
   logic        ascii_wr_en;
   logic [12:0] cursor;

   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q[$];
   int   m_row = 0;
   int   m_col = 0;
   bit   exp_run = 1'b0;
   int   since = 1000;
   int   last_pop_addr = -1;
   bit   last_pop_clr = 1'b0;

   text_term_ctrl dut (
      .clk           (clk),
      .resetn        (resetn),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .ascii_address (ascii_address),
      .ascii_data    (ascii_data),
      .ascii_wr_en   (ascii_wr_en),
      .cursor        (cursor)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic push_clear(input int base, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back('{base + i, 8'h20, 1'b1});
   endtask

   task automatic advance_row();
      m_col = 0;
      m_row = (m_row + 1) % TB_ROWS;
      push_clear(m_row * TB_COLS, TB_COLS);
   endtask

   // Screen-level effect of one accepted byte.
   task automatic model_byte(input logic [7:0] d, output bit wr);
      wr = 1'b0;
      if (d >= 8'h20 && d <= 8'h7E) begin
         exp_q.push_back('{m_row * TB_COLS + m_col, d, 1'b0});
         wr = 1'b1;
         m_col++;
         if (m_col == TB_COLS) advance_row();
      end else if (d == 8'h0A) begin
         advance_row();
      end else if (d == 8'h0D) begin
         m_col = 0;
      end else if (d == 8'h08) begin
         if (m_col > 0) m_col--;
         else if (m_row > 0) begin m_row--; m_col = TB_COLS - 1; end
         exp_q.push_back('{m_row * TB_COLS + m_col, 8'h20, 1'b0});
         wr = 1'b1;
      end else if (d == 8'h0C) begin
         m_row = 0;
         m_col = 0;
         push_clear(0, TB_COLS * TB_ROWS);
      end
   endtask

   task automatic observe(input bit acc, input bit exp_wr);
      wr_t e;
      if (since < 1000) since++;
      last_pop_clr = 1'b0;
      check_val("cursor", cursor, m_row * TB_COLS + m_col);
      if (exp_run) check_val("clear_run", ascii_wr_en, 1);
      exp_run = 1'b0;
      if (acc) check_val("wr_at_n1", ascii_wr_en, exp_wr);
      if (ascii_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_wr", ascii_wr_en, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", ascii_address, e.addr);
            check_val("wr_data", ascii_data, e.data);
            last_pop_addr = e.addr;
            last_pop_clr  = e.clr;
            if (e.clr && exp_q.size() == 0) since = 0;
            if (e.clr && exp_q.size() > 0) exp_run = 1'b1;
         end
      end
      if (exp_q.size() > 0 || since == 0) check_val("rx_ready_busy", rx_ready, 0);
      else if (since >= 2) check_val("rx_ready_idle", rx_ready, 1);
   endtask

   task automatic tick(input logic v, input logic [7:0] d);
      bit acc;
      bit w;
      rx_valid = v;
      rx_data  = d;
      acc = v && (rx_ready === 1'b1);
      w = 1'b0;
      @(negedge clk);
      if (acc) model_byte(d, w);
      observe(acc, w);
   endtask

   task automatic send(input logic [7:0] d);
      int n = 0;
      while (rx_ready !== 1'b1 && n < 6000) begin
         tick(1'($urandom_range(0, 1)), 8'($urandom));
         n++;
      end
      check_val("ready_wait", rx_ready, 1);
      tick(1'b1, d);
      rx_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 6000) begin
         tick(1'b0, 8'h00);
         n++;
      end
      check_val("drain_done", exp_q.size(), 0);
      for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
   endtask

   task automatic apply_reset();
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      @(negedge clk);
      check_val("rst_wr_en", ascii_wr_en, 0);
      check_val("rst_addr", ascii_address, 0);
      check_val("rst_data", ascii_data, 0);
      check_val("rst_cursor", cursor, 0);
      check_val("rst_ready", rx_ready, 0);
      exp_q.delete();
      m_row   = 0;
      m_col   = 0;
      exp_run = 1'b0;
      since   = 1000;
      push_clear(0, TB_COLS * TB_ROWS);
      resetn  = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      int r;
      int n;
      resetn   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      apply_reset();
      drain();
      check_val("idle_after_clear", rx_ready, 1);

      send(8'h41);
      send(8'h42);
      check_val("ab_ready", rx_ready, 1);
      check_val("ab_cursor", cursor, 2);
      send(8'h0D);

      for (int i = 0; i < TB_COLS; i++) send(8'(8'h21 + (i % 90)));
      check_val("wrap_cursor", cursor, 80);
      drain();
      send(8'h08);
      check_val("bs_wrap_cursor", cursor, 79);
      send(8'h0D);
      send(8'h08);
      check_val("bs_home_cursor", cursor, 0);
      send(8'h07);
      send(8'h80);
      check_val("ignored_cursor", cursor, 0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick(1'b0, 8'h00);
         r = $urandom_range(0, 99);
         if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
         else if (r < 78) b = 8'h0A;
         else if (r < 84) b = 8'h0D;
         else if (r < 92) b = 8'h08;
         else if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 7));
         else             b = 8'($urandom_range(8'h7F, 8'hFF));
         send(b);
      end
      drain();

      send(8'h0C);
      n = 0;
      do begin
         tick(1'b0, 8'h00);
         n++;
      end while (!(last_pop_clr && last_pop_addr == 1000) && n < 6000);
      check_val("reached_1000", last_pop_addr, 1000);
      apply_reset();
      drain();

      for (int i = 0; i < TB_ROWS - 1; i++) send(8'h0A);
      drain();
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
      check_val("row59_cursor", cursor, 59 * 80 + 5);
      send(8'h0A);
      check_val("lf_wrap_cursor", cursor, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
